hue_arbiter: RTL

Round-robin arbiter that shares one hue conversion pipeline (RGB565 in, 16-bit hue in degrees out) between two independent RGB565 pixel requesters. It grants one pixel per cycle into the pipeline, tracks the owner of every in-flight pixel in a tag FIFO, and routes each returning hue result to its requester's output port. It sits between the two camera/pixel sources and the shared hue pipeline in the color-detect path.

---
 rtl/hue_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hue_arbiter.sv
// hue_arbiter: round-robin share of one in-order hue pipeline between two RGB565
// requesters. A 1-bit tag FIFO records the owner of every in-flight pixel so each
// returning hue result is steered back to the requester that issued it.
module hue_arbiter #(
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_req0_data,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [15:0] i_req1_data,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  output logic [15:0] o_pipe_data,
  output logic        o_pipe_valid,
  input  logic [15:0] i_pipe_data,
  input  logic        i_pipe_valid,
  output logic [15:0] o_hue0_data,
  output logic        o_hue0_valid,
  output logic [15:0] o_hue1_data,
  output logic        o_hue1_valid,
  output logic        o_busy,
  output logic        o_err
);

  localparam int unsigned PtrW = (TAG_DEPTH > 2) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(TAG_DEPTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TAG_DEPTH);

  // State
  logic [CntW-1:0]      count_q, count_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [TAG_DEPTH-1:0] tag_q, tag_d;
  logic                 last_q, last_d;
  logic [15:0]          pipe_data_q, pipe_data_d;
  logic                 pipe_valid_q, pipe_valid_d;
  logic [15:0]          hue0_data_q, hue0_data_d;
  logic                 hue0_valid_q, hue0_valid_d;
  logic [15:0]          hue1_data_q, hue1_data_d;
  logic                 hue1_valid_q, hue1_valid_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  // Per-cycle decisions
  logic can_issue;
  logic gnt0, gnt1;
  logic push, pop;
  logic pop_tag;

  // Grant: issue only below full on the registered count; a tie goes to the
  // requester that was not granted last. Readys are held low during reset.
  always_comb begin
    can_issue = (count_q < CntMax);
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (can_issue && !i_rst) begin
      if (i_req0_valid && i_req1_valid) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = i_req0_valid;
        gnt1 = i_req1_valid;
      end
    end
  end

  assign push    = gnt0 | gnt1;
  assign pop     = i_pipe_valid && (count_q != '0);
  assign pop_tag = tag_q[rd_ptr_q];

  // Next-state: tag FIFO push/pop, pipeline issue register, result routing.
  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tag_d        = tag_q;
    last_d       = last_q;
    pipe_data_d  = pipe_data_q;
    pipe_valid_d = push;
    hue0_data_d  = hue0_data_q;
    hue1_data_d  = hue1_data_q;
    hue0_valid_d = pop && !pop_tag;
    hue1_valid_d = pop && pop_tag;
    // A result with nothing in flight has no owner; drop it and flag it.
    err_d        = err_q | (i_pipe_valid && (count_q == '0));

    if (push) begin
      tag_d[wr_ptr_q] = gnt1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      last_d          = gnt1;
      pipe_data_d     = gnt1 ? i_req1_data : i_req0_data;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (hue0_valid_d) begin
      hue0_data_d = i_pipe_data;
    end
    if (hue1_valid_d) begin
      hue1_data_d = i_pipe_data;
    end

    busy_d = (count_d != '0);
  end

  // State registers with synchronous reset; last_q resets to 1 so requester 0
  // wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_q        <= '0;
      last_q       <= 1'b1;
      pipe_data_q  <= '0;
      pipe_valid_q <= 1'b0;
      hue0_data_q  <= '0;
      hue0_valid_q <= 1'b0;
      hue1_data_q  <= '0;
      hue1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_q        <= tag_d;
      last_q       <= last_d;
      pipe_data_q  <= pipe_data_d;
      pipe_valid_q <= pipe_valid_d;
      hue0_data_q  <= hue0_data_d;
      hue0_valid_q <= hue0_valid_d;
      hue1_data_q  <= hue1_data_d;
      hue1_valid_q <= hue1_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;
  assign o_pipe_data  = pipe_data_q;
  assign o_pipe_valid = pipe_valid_q;
  assign o_hue0_data  = hue0_data_q;
  assign o_hue0_valid = hue0_valid_q;
  assign o_hue1_data  = hue1_data_q;
  assign o_hue1_valid = hue1_valid_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;

endmodule
